// File: rtl/johnson_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// johnson_seq_ctrl_if
// Command, control and status bundle between a control master and the
// Johnson-counter sequencer (johnson_seq_ctrl).
//
// Parameters (must match the johnson_seq_ctrl instance it is bound to):
//   WIDTH  - number of Johnson stages (sequence length 2*WIDTH), >= 2
//   STEP_W - width of the step-count field
//   PH_W   - width of the phase index
//
// Signals:
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  sequencer can accept a command
//   cmd_dir    master->slave  0 = up, 1 = down
//   cmd_steps  master->slave  number of counter advances
//   hold       master->slave  freeze stepping while high
//   abort      master->slave  cancel the running command
//   count      slave->master  Johnson counter value
//   phase      slave->master  position of count in the up sequence
//   busy       slave->master  command in progress
//   step_tick  slave->master  high in the cycle after each advance
//   done       slave->master  one-cycle completion pulse
//   err        slave->master  one-cycle illegal-load flag
//
// Optional feature macro: JOHNSON_LOAD_EN adds cmd_load / cmd_load_val.
// ---------------------------------------------------------------------------
interface johnson_seq_ctrl_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8,
  parameter int PH_W   = $clog2(2 * WIDTH)
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              hold;
  logic              abort;
`ifdef JOHNSON_LOAD_EN
  logic              cmd_load;
  logic [WIDTH-1:0]  cmd_load_val;
`endif
  logic [WIDTH-1:0]  count;
  logic [PH_W-1:0]   phase;
  logic              busy;
  logic              step_tick;
  logic              done;
  logic              err;

`ifdef JOHNSON_LOAD_EN
  modport master (
    output cmd_valid, cmd_dir, cmd_steps, hold, abort, cmd_load, cmd_load_val,
    input  cmd_ready, count, phase, busy, step_tick, done, err
  );
  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, hold, abort, cmd_load, cmd_load_val,
    output cmd_ready, count, phase, busy, step_tick, done, err
  );
`else
  modport master (
    output cmd_valid, cmd_dir, cmd_steps, hold, abort,
    input  cmd_ready, count, phase, busy, step_tick, done, err
  );
  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, hold, abort,
    output cmd_ready, count, phase, busy, step_tick, done, err
  );
`endif
endinterface

// File: rtl/johnson_seq_ctrl.sv
// ---------------------------------------------------------------------------
// johnson_seq_ctrl
// Command-driven sequencer owning a WIDTH-stage Johnson counter. One command
// is accepted per cmd_valid/cmd_ready handshake; the counter is then stepped
// cmd_steps positions up or down, and done pulses for one cycle at the end.
// hold freezes stepping, abort cancels the command (abort wins over hold).
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - johnson_seq_ctrl_if.slave: command handshake, hold/abort controls
//          and count/phase/busy/step_tick/done/err status
//
// Optional feature macro: JOHNSON_LOAD_EN
//   When defined, a command with cmd_load=1 loads cmd_load_val directly into
//   the counter (if it is a legal Johnson code) and completes immediately;
//   an illegal code leaves count unchanged and raises err alongside done.
//   When undefined, err is tied low.
// ---------------------------------------------------------------------------
module johnson_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8,
  parameter int PH_W   = $clog2(2 * WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  johnson_seq_ctrl_if.slave     bus
);

  localparam int unsigned    NSTATES   = 2 * WIDTH;
  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  CNT_ZERO  = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Next Johnson code going up: shift left, feed back the inverted MSB.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c);
    return {c[WIDTH-2:0], ~c[WIDTH-1]};
  endfunction

  // Next Johnson code going down: shift right, feed back the inverted LSB.
  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] c);
    return {~c[0], c[WIDTH-1:1]};
  endfunction

  function automatic int unsigned popcount(input logic [WIDTH-1:0] c);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + int'(c[i]);
    end
    return ones;
  endfunction

  // In the up sequence the filling half (LSB set, or all zero) has
  // phase = number of ones; the draining half has phase = 2*WIDTH - ones.
  function automatic logic [PH_W-1:0] phase_of(input logic [WIDTH-1:0] c);
    int unsigned ones;
    ones = popcount(c);
    if (c[0] || (c == CNT_ZERO)) begin
      return PH_W'(ones);
    end else begin
      return PH_W'(NSTATES - ones);
    end
  endfunction

`ifdef JOHNSON_LOAD_EN
  // A legal Johnson code has at most one boundary between adjacent bits.
  function automatic logic load_legal(input logic [WIDTH-1:0] v);
    int unsigned edges;
    edges = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (v[i] != v[i+1]) begin
        edges = edges + 1;
      end
    end
    return (edges <= 1);
  endfunction
`endif

  state_t            state_r;
  logic [WIDTH-1:0]  count_r;
  logic [STEP_W-1:0] remaining_r;
  logic              dir_r;
  logic              busy_r;
  logic              done_r;
  logic              step_tick_r;
  logic              ready_r;
`ifdef JOHNSON_LOAD_EN
  logic              err_r;
`endif
  logic [PH_W-1:0]   phase_s;

  // Phase index decoded combinationally from the counter register.
  always_comb begin
    phase_s = phase_of(count_r);
  end

  // Sequencer FSM: command capture, stepping, hold/abort and completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      count_r     <= CNT_ZERO;
      remaining_r <= STEP_ZERO;
      dir_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      step_tick_r <= 1'b0;
      ready_r     <= 1'b1;
`ifdef JOHNSON_LOAD_EN
      err_r       <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; the branches below raise them.
      done_r      <= 1'b0;
      step_tick_r <= 1'b0;
`ifdef JOHNSON_LOAD_EN
      err_r       <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid && ready_r) begin
            ready_r <= 1'b0;
`ifdef JOHNSON_LOAD_EN
            if (bus.cmd_load) begin
              // Loads finish in one cycle; illegal codes are rejected.
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              if (load_legal(bus.cmd_load_val)) begin
                count_r <= bus.cmd_load_val;
              end else begin
                err_r   <= 1'b1;
              end
            end else
`endif
            begin
              dir_r       <= bus.cmd_dir;
              remaining_r <= bus.cmd_steps;
              if (bus.cmd_steps != STEP_ZERO) begin
                state_r <= ST_RUN;
                busy_r  <= 1'b1;
              end else begin
                // Zero-length command completes without touching count.
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end
            end
          end else begin
            ready_r <= 1'b1;
          end
        end

        ST_RUN: begin
          if (bus.abort) begin
            // Abort overrides hold: drop the command, keep count, no done.
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
            remaining_r <= STEP_ZERO;
          end else if (!bus.hold) begin
            count_r     <= dir_r ? step_down(count_r) : step_up(count_r);
            remaining_r <= remaining_r - STEP_ONE;
            step_tick_r <= 1'b1;
            if (remaining_r == STEP_ONE) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.count     = count_r;
  assign bus.phase     = phase_s;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.step_tick = step_tick_r;
  assign bus.cmd_ready = ready_r;
`ifdef JOHNSON_LOAD_EN
  assign bus.err       = err_r;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_johnson_seq_ctrl
// Directed self-checking bench for johnson_seq_ctrl (WIDTH=4, STEP_W=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Load-feature scenarios are compiled in only with JOHNSON_LOAD_EN.
// ---------------------------------------------------------------------------
module tb_johnson_seq_ctrl;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 8;
  localparam int PH_W   = 3;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  johnson_seq_ctrl_if #(.WIDTH(WIDTH), .STEP_W(STEP_W), .PH_W(PH_W)) bus ();

  johnson_seq_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W), .PH_W(PH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic dir, input logic [STEP_W-1:0] steps);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_steps = steps;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Short async reset pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (bus.count !== 4'b0000) begin errors++; $display("FAIL rst_count got=%b exp=0000", bus.count); end
    checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL rst_phase got=%0d exp=0", bus.phase); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    checks++; if (bus.step_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", bus.step_tick); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_up3();
    logic [3:0] exp_c [0:2];
    exp_c[0] = 4'b0001; exp_c[1] = 4'b0011; exp_c[2] = 4'b0111;
    send(1'b0, 8'd3);
    checks++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL up3_accept busy=%b ready=%b exp busy=1 ready=0", bus.busy, bus.cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.count !== exp_c[i]) begin errors++; $display("FAIL up3_count[%0d] got=%b exp=%b", i, bus.count, exp_c[i]); end
      checks++; if (bus.step_tick !== 1'b1) begin errors++; $display("FAIL up3_tick[%0d] got=%b exp=1", i, bus.step_tick); end
      checks++; if (bus.done !== (i == 2)) begin errors++; $display("FAIL up3_done[%0d] got=%b exp=%b", i, bus.done, (i == 2)); end
    end
    checks++; if (bus.phase !== 3'd3) begin errors++; $display("FAIL up3_phase got=%0d exp=3", bus.phase); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL up3_busy_done got=%b exp=0", bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL up3_after done=%b ready=%b exp done=0 ready=1", bus.done, bus.cmd_ready); end
  endtask

  task automatic test_down9();
    logic [3:0] exp_c [0:8];
    int ticks;
    int busy_cycles;
    exp_c[0] = 4'b1000; exp_c[1] = 4'b1100; exp_c[2] = 4'b1110;
    exp_c[3] = 4'b1111; exp_c[4] = 4'b0111; exp_c[5] = 4'b0011;
    exp_c[6] = 4'b0001; exp_c[7] = 4'b0000; exp_c[8] = 4'b1000;
    do_reset();
    tick();
    send(1'b1, 8'd9);
    ticks = 0;
    busy_cycles = int'(bus.busy);
    for (int i = 0; i < 9; i++) begin
      tick();
      ticks = ticks + int'(bus.step_tick);
      busy_cycles = busy_cycles + int'(bus.busy);
      checks++; if (bus.count !== exp_c[i]) begin errors++; $display("FAIL down9_count[%0d] got=%b exp=%b", i, bus.count, exp_c[i]); end
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL down9_done got=%b exp=1", bus.done); end
    checks++; if (bus.phase !== 3'd7) begin errors++; $display("FAIL down9_phase got=%0d exp=7", bus.phase); end
    tick();
    ticks = ticks + int'(bus.step_tick);
    busy_cycles = busy_cycles + int'(bus.busy);
    checks++; if (ticks !== 9) begin errors++; $display("FAIL down9_ticks got=%0d exp=9", ticks); end
    checks++; if (busy_cycles !== 9) begin errors++; $display("FAIL down9_busy_cycles got=%0d exp=9", busy_cycles); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL down9_done_len got=%b exp=0", bus.done); end
  endtask

  task automatic test_hold();
    logic [3:0] exp_c [0:5];
    logic       exp_t [0:5];
    exp_c[0] = 4'b0001; exp_c[1] = 4'b0011; exp_c[2] = 4'b0011;
    exp_c[3] = 4'b0011; exp_c[4] = 4'b0111; exp_c[5] = 4'b1111;
    exp_t[0] = 1'b1; exp_t[1] = 1'b1; exp_t[2] = 1'b0;
    exp_t[3] = 1'b0; exp_t[4] = 1'b1; exp_t[5] = 1'b1;
    do_reset();
    tick();
    send(1'b0, 8'd4);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus.count !== exp_c[i]) begin errors++; $display("FAIL hold_count[%0d] got=%b exp=%b", i, bus.count, exp_c[i]); end
      checks++; if (bus.step_tick !== exp_t[i]) begin errors++; $display("FAIL hold_tick[%0d] got=%b exp=%b", i, bus.step_tick, exp_t[i]); end
      checks++; if (bus.done !== (i == 5)) begin errors++; $display("FAIL hold_done[%0d] got=%b exp=%b", i, bus.done, (i == 5)); end
      if (i == 1) bus.hold = 1'b1;
      if (i == 3) bus.hold = 1'b0;
    end
  endtask

  task automatic test_abort();
    do_reset();
    tick();
    send(1'b0, 8'd5);
    tick();
    tick();
    checks++; if (bus.count !== 4'b0011) begin errors++; $display("FAIL abort_pre_count got=%b exp=0011", bus.count); end
    bus.abort = 1'b1;
    bus.hold  = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    checks++; if (bus.count !== 4'b0011) begin errors++; $display("FAIL abort_count got=%b exp=0011", bus.count); end
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_flags done=%b busy=%b exp done=0 busy=0", bus.done, bus.busy); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", bus.cmd_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.count !== 4'b0011 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_idle[%0d] count=%b done=%b exp count=0011 done=0", i, bus.count, bus.done); end
    end
    send(1'b1, 8'd0);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero_done done=%b busy=%b exp done=1 busy=0", bus.done, bus.busy); end
    checks++; if (bus.count !== 4'b0011) begin errors++; $display("FAIL zero_count got=%b exp=0011", bus.count); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_after done=%b ready=%b exp done=0 ready=1", bus.done, bus.cmd_ready); end
  endtask

  task automatic test_async_reset();
    int dones;
    do_reset();
    tick();
    send(1'b0, 8'd5);
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.count !== 4'b0000) begin errors++; $display("FAIL arst_count got=%b exp=0000", bus.count); end
    checks++; if (bus.busy !== 1'b0 || bus.step_tick !== 1'b0) begin errors++; $display("FAIL arst_flags busy=%b tick=%b exp 0 0", bus.busy, bus.step_tick); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", bus.cmd_ready); end
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      dones = dones + int'(bus.done);
    end
    checks++; if (dones !== 0 || bus.count !== 4'b0000) begin errors++; $display("FAIL arst_after dones=%0d count=%b exp 0 0000", dones, bus.count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b0;
    bus.cmd_steps = 8'd1;
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy1 got=%b exp=1", bus.busy); end
    tick();
    checks++; if (bus.count !== 4'b0001 || bus.done !== 1'b1 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_done1 count=%b done=%b ready=%b exp 0001 1 0", bus.count, bus.done, bus.cmd_ready); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle done=%b ready=%b busy=%b exp 0 1 0", bus.done, bus.cmd_ready, bus.busy); end
    bus.abort = 1'b1;
    bus.hold  = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.count !== 4'b0001) begin errors++; $display("FAIL b2b_accept2 busy=%b count=%b exp 1 0001", bus.busy, bus.count); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.count !== 4'b0011 || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done2 count=%b done=%b exp 0011 1", bus.count, bus.done); end
    tick();
    checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_end ready=%b busy=%b exp 1 0", bus.cmd_ready, bus.busy); end
  endtask

`ifdef JOHNSON_LOAD_EN
  task automatic test_load();
    bus.cmd_load     = 1'b1;
    bus.cmd_load_val = 4'b1100;
    send(1'b0, 8'd7);
    checks++; if (bus.count !== 4'b1100 || bus.phase !== 3'd6) begin errors++; $display("FAIL load_ok count=%b phase=%0d exp 1100 6", bus.count, bus.phase); end
    checks++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL load_ok_flags done=%b err=%b exp 1 0", bus.done, bus.err); end
    tick();
    checks++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL load_ok_after ready=%b done=%b exp 1 0", bus.cmd_ready, bus.done); end
    bus.cmd_load_val = 4'b0110;
    send(1'b0, 8'd7);
    checks++; if (bus.count !== 4'b1100) begin errors++; $display("FAIL load_bad_count got=%b exp=1100", bus.count); end
    checks++; if (bus.done !== 1'b1 || bus.err !== 1'b1) begin errors++; $display("FAIL load_bad_flags done=%b err=%b exp 1 1", bus.done, bus.err); end
    bus.cmd_load = 1'b0;
    tick();
    checks++; if (bus.err !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL load_bad_after err=%b done=%b exp 0 0", bus.err, bus.done); end
  endtask
`endif

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_steps = 8'd0;
    bus.hold      = 1'b0;
    bus.abort     = 1'b0;
`ifdef JOHNSON_LOAD_EN
    bus.cmd_load     = 1'b0;
    bus.cmd_load_val = 4'b0000;
`endif
    test_reset();
    test_up3();
    test_down9();
    test_hold();
    test_abort();
    test_async_reset();
    test_back_to_back();
`ifdef JOHNSON_LOAD_EN
    test_load();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
